// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS32 control FSM.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SUBI  = 6'b001001;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_REG    = 2'b00;
  localparam logic [1:0] ALUB_FOUR   = 2'b01;
  localparam logic [1:0] ALUB_IMM    = 2'b10;
  localparam logic [1:0] ALUB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    ST_RESET,
    ST_FETCH,
    ST_DECODE,
    ST_MEMADR,
    ST_MEMRD,
    ST_MEMWB,
    ST_MEMWR,
    ST_EXEC,
    ST_ALUWB,
    ST_BRANCH,
    ST_JUMP,
    ST_IMMEX,
    ST_IMMWB,
    ST_HALTED
  } state_t;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: wraps modulo 2^CNT_W, async active-low reset.
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Count one per retire pulse; natural overflow gives the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS32 datapath.
// Optional single-step support is compiled in with `define SINGLE_STEP_EN.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef SINGLE_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_source,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_opcode;
  logic       w_fetch_hold;
  logic       w_unused_zero;

  // The zero flag is combined with pc_write_cond outside this block.
  assign w_unused_zero = zero;

`ifdef SINGLE_STEP_EN
  logic r_step_pending;

  assign w_fetch_hold = step_mode & ~r_step_pending;

  // Arm one instruction per step pulse; disarm once its fetch completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_step_pending <= 1'b0;
    end else if (step) begin
      r_step_pending <= 1'b1;
    end else if (r_state == ST_FETCH && !w_fetch_hold && mem_ready) begin
      r_step_pending <= 1'b0;
    end
  end
`else
  assign w_fetch_hold = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the opcode in DECODE so later states ignore IR bus changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= 6'd0;
    end else if (r_state == ST_DECODE) begin
      r_opcode <= opcode;
    end
  end

  // Next-state and Moore outputs; everything idles at 0 unless a state drives it.
  always_comb begin
    w_next        = r_state;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = PCSRC_ALU;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUB_REG;
    alu_op        = ALUOP_ADD;
    halted        = 1'b0;
    illegal_op    = 1'b0;
    instr_done    = 1'b0;
    case (r_state)
      ST_RESET: w_next = ST_FETCH;
      ST_FETCH: begin
        if (!w_fetch_hold) begin
          mem_read  = 1'b1;
          alu_src_b = ALUB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
          if (mem_ready) w_next = ST_DECODE;
        end
      end
      ST_DECODE: begin
        alu_src_b = ALUB_IMMSH2;
        case (opcode)
          OP_RTYPE:      w_next = ST_EXEC;
          OP_LW, OP_SW:  w_next = ST_MEMADR;
          OP_BEQ:        w_next = ST_BRANCH;
          OP_J:          w_next = ST_JUMP;
          OP_ADDI,
          OP_SUBI:       w_next = ST_IMMEX;
          OP_HALT: begin
            instr_done = 1'b1;
            w_next     = ST_HALTED;
          end
          default: begin
            illegal_op = 1'b1;
            w_next     = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        w_next    = (r_opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) w_next = ST_MEMWB;
      end
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) w_next = ST_FETCH;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        w_next    = ST_ALUWB;
      end
      ST_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
        instr_done    = 1'b1;
        w_next        = ST_FETCH;
      end
      ST_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUB_IMM;
        alu_op    = (r_opcode == OP_SUBI) ? ALUOP_SUB : ALUOP_ADD;
        w_next    = ST_IMMWB;
      end
      ST_IMMWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        w_next     = ST_FETCH;
      end
      ST_HALTED: halted = 1'b1;
      default:   w_next = ST_RESET;
    endcase
  end

  retire_counter #(.CNT_W(CNT_W)) u_retire_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (instr_done),
    .o_count (instret)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each scenario queues per-cycle
// stimulus and expected outputs, then replays and compares cycle by cycle.
module tb_multicycle_ctrl;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpSubi  = 6'b001001;
  localparam logic [5:0] OpHalt  = 6'b111111;

  typedef struct packed {
    logic [5:0] op;
    logic       mr;
    logic       z;
  } stim_t;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a, halted, illegal_op, instr_done;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] instret;
  logic [23:0] obsVec;

  stim_t       stimQ[$];
  logic [23:0] expQ[$];
  logic [3:0]  expCnt;
  int          checks;
  int          errors;

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .halted        (halted),
    .illegal_op    (illegal_op),
    .instr_done    (instr_done),
    .instret       (instret)
  );

  assign obsVec = {pc_write, pc_write_cond, pc_source, iord, mem_read, mem_write, ir_write,
                   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
                   halted, illegal_op, instr_done, instret};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack one cycle's expected control outputs; instr_done ends up in bit 0.
  function automatic logic [19:0] sigv(
    input logic pcw, input logic pcwc, input logic [1:0] pcsrc, input logic io,
    input logic mrd, input logic mwr, input logic irw, input logic rdst, input logic m2r,
    input logic rw, input logic a, input logic [1:0] b, input logic [1:0] aop,
    input logic h, input logic ill, input logic done);
    return {pcw, pcwc, pcsrc, io, mrd, mwr, irw, rdst, m2r, rw, a, b, aop, h, ill, done};
  endfunction

  // Queue one cycle of stimulus with its expected outputs and counter value.
  task automatic pushCycle(input logic [5:0] op, input logic mr, input logic z,
                           input logic [19:0] sig);
    stimQ.push_back({op, mr, z});
    expQ.push_back({sig, expCnt});
    if (sig[0]) expCnt = expCnt + 4'd1;
  endtask

  // Queue a whole instruction; the opcode bus is scrambled after DECODE.
  task automatic pushInstr(input logic [5:0] op, input logic z,
                           input int fetchWait, input int memWait);
    logic [5:0] junk;
    logic       legal;
    junk  = op ^ 6'h3F;
    legal = (op == OpRtype) || (op == OpLw) || (op == OpSw) || (op == OpBeq) ||
            (op == OpJ) || (op == OpAddi) || (op == OpSubi) || (op == OpHalt);
    repeat (fetchWait)
      pushCycle(op, 1'b0, z, sigv(0,0,2'b00,0,1,0,0,0,0,0,0,2'b01,2'b00,0,0,0));
    pushCycle(op, 1'b1, z, sigv(1,0,2'b00,0,1,0,1,0,0,0,0,2'b01,2'b00,0,0,0));
    pushCycle(op, 1'b1, z, sigv(0,0,2'b00,0,0,0,0,0,0,0,0,2'b11,2'b00,0,!legal,op == OpHalt));
    case (op)
      OpRtype: begin
        pushCycle(junk, 1'b1, z, sigv(0,0,2'b00,0,0,0,0,0,0,0,1,2'b00,2'b10,0,0,0));
        pushCycle(junk, 1'b1, z, sigv(0,0,2'b00,0,0,0,0,1,0,1,0,2'b00,2'b00,0,0,1));
      end
      OpLw: begin
        pushCycle(junk, 1'b1, z, sigv(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,0));
        repeat (memWait)
          pushCycle(junk, 1'b0, z, sigv(0,0,2'b00,1,1,0,0,0,0,0,0,2'b00,2'b00,0,0,0));
        pushCycle(junk, 1'b1, z, sigv(0,0,2'b00,1,1,0,0,0,0,0,0,2'b00,2'b00,0,0,0));
        pushCycle(junk, 1'b1, z, sigv(0,0,2'b00,0,0,0,0,0,1,1,0,2'b00,2'b00,0,0,1));
      end
      OpSw: begin
        pushCycle(junk, 1'b1, z, sigv(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,0));
        repeat (memWait)
          pushCycle(junk, 1'b0, z, sigv(0,0,2'b00,1,0,1,0,0,0,0,0,2'b00,2'b00,0,0,0));
        pushCycle(junk, 1'b1, z, sigv(0,0,2'b00,1,0,1,0,0,0,0,0,2'b00,2'b00,0,0,1));
      end
      OpBeq:
        pushCycle(junk, 1'b1, z, sigv(0,1,2'b01,0,0,0,0,0,0,0,1,2'b00,2'b01,0,0,1));
      OpJ:
        pushCycle(junk, 1'b1, z, sigv(1,0,2'b10,0,0,0,0,0,0,0,0,2'b00,2'b00,0,0,1));
      OpAddi, OpSubi: begin
        pushCycle(junk, 1'b1, z, sigv(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,
                                      (op == OpSubi) ? 2'b01 : 2'b00,0,0,0));
        pushCycle(junk, 1'b1, z, sigv(0,0,2'b00,0,0,0,0,0,0,1,0,2'b00,2'b00,0,0,1));
      end
      default: ;
    endcase
  endtask

  // Drive the next queued stimulus, then fetch its expectation at the sampling edge.
  task automatic applyStimulus(output logic [23:0] e);
    stim_t s;
    s         = stimQ.pop_front();
    opcode    = s.op;
    mem_ready = s.mr;
    zero      = s.z;
    @(negedge clk);
    e = expQ.pop_front();
  endtask

  task automatic test_reset;
    logic [23:0] e;
    int cyc;
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = OpLw;
    expCnt    = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obsVec !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_hold got %h expected %h", obsVec, 24'h0);
    end
    rst_n = 1'b1;
    pushCycle(OpLw, 1'b1, 1'b0, 20'h0);
    pushCycle(OpLw, 1'b0, 1'b0, sigv(0,0,2'b00,0,1,0,0,0,0,0,0,2'b01,2'b00,0,0,0));
    cyc = 0;
    while (expQ.size() > 0) begin
      applyStimulus(e);
      checks++;
      if (obsVec !== e) begin
        errors++;
        $display("[TB] FAIL reset cycle %0d got %h expected %h", cyc, obsVec, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype;
    logic [23:0] e;
    int cyc;
    pushInstr(OpRtype, 1'b0, 0, 0);
    pushInstr(OpAddi,  1'b1, 0, 0);
    pushInstr(OpJ,     1'b0, 2, 0);
    cyc = 0;
    while (expQ.size() > 0) begin
      applyStimulus(e);
      checks++;
      if (obsVec !== e) begin
        errors++;
        $display("[TB] FAIL alu_jump cycle %0d got %h expected %h", cyc, obsVec, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_memory;
    logic [23:0] e;
    int cyc;
    pushInstr(OpLw, 1'b0, 0, 3);
    pushInstr(OpSw, 1'b1, 1, 2);
    pushInstr(OpSw, 1'b0, 0, 0);
    cyc = 0;
    while (expQ.size() > 0) begin
      applyStimulus(e);
      checks++;
      if (obsVec !== e) begin
        errors++;
        $display("[TB] FAIL memory cycle %0d got %h expected %h", cyc, obsVec, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch;
    logic [23:0] e;
    int cyc;
    pushInstr(OpBeq, 1'b1, 0, 0);
    pushInstr(OpBeq, 1'b0, 0, 0);
    cyc = 0;
    while (expQ.size() > 0) begin
      applyStimulus(e);
      checks++;
      if (obsVec !== e) begin
        errors++;
        $display("[TB] FAIL branch cycle %0d got %h expected %h", cyc, obsVec, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal;
    logic [23:0] e;
    int cyc;
    pushInstr(6'b001100, 1'b0, 0, 0);
    pushInstr(6'b110000, 1'b0, 0, 0);
    pushInstr(OpRtype,   1'b0, 0, 0);
    cyc = 0;
    while (expQ.size() > 0) begin
      applyStimulus(e);
      checks++;
      if (obsVec !== e) begin
        errors++;
        $display("[TB] FAIL illegal cycle %0d got %h expected %h", cyc, obsVec, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap;
    logic [23:0] e;
    logic [3:0]  startCnt;
    int cyc;
    startCnt = expCnt;
    for (int i = 0; i < 16; i++) pushInstr(OpSubi, i[0], 0, 0);
    cyc = 0;
    while (expQ.size() > 0) begin
      applyStimulus(e);
      checks++;
      if (obsVec !== e) begin
        errors++;
        $display("[TB] FAIL wrap cycle %0d got %h expected %h", cyc, obsVec, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    checks++;
    if (instret !== startCnt) begin
      errors++;
      $display("[TB] FAIL wrap_count got %0d expected %0d", instret, startCnt);
    end
  endtask

  task automatic test_halt;
    logic [23:0] e;
    int cyc;
    pushInstr(OpHalt, 1'b0, 1, 0);
    for (int i = 0; i < 22; i++)
      pushCycle(6'($urandom), 1'($urandom), 1'($urandom),
                sigv(0,0,2'b00,0,0,0,0,0,0,0,0,2'b00,2'b00,1,0,0));
    cyc = 0;
    while (expQ.size() > 0) begin
      applyStimulus(e);
      checks++;
      if (obsVec !== e) begin
        errors++;
        $display("[TB] FAIL halt cycle %0d got %h expected %h", cyc, obsVec, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid;
    logic [23:0] e;
    int cyc;
    pushCycle(OpLw, 1'b1, 1'b0, sigv(1,0,2'b00,0,1,0,1,0,0,0,0,2'b01,2'b00,0,0,0));
    pushCycle(OpLw, 1'b1, 1'b0, sigv(0,0,2'b00,0,0,0,0,0,0,0,0,2'b11,2'b00,0,0,0));
    pushCycle(OpLw, 1'b1, 1'b0, sigv(0,0,2'b00,0,0,0,0,0,0,0,1,2'b10,2'b00,0,0,0));
    repeat (2)
      pushCycle(OpLw, 1'b0, 1'b0, sigv(0,0,2'b00,1,1,0,0,0,0,0,0,2'b00,2'b00,0,0,0));
    cyc = 0;
    while (expQ.size() > 0) begin
      applyStimulus(e);
      checks++;
      if (obsVec !== e) begin
        errors++;
        $display("[TB] FAIL reset_mid cycle %0d got %h expected %h", cyc, obsVec, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    #1;
    checks++;
    if (obsVec !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_async got %h expected %h", obsVec, 24'h0);
    end
    @(posedge clk); #1;
    checks++;
    if (obsVec !== 24'h0) begin
      errors++;
      $display("[TB] FAIL reset_mid_hold got %h expected %h", obsVec, 24'h0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = 6'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    checks    = 0;
    errors    = 0;
    expCnt    = 4'd0;
    test_reset();
    test_rtype();
    test_memory();
    test_branch();
    test_illegal();
    test_wrap();
    test_halt();
    test_reset();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style control FSM that sequences the shared MIPS32 datapath over multiple cycles: one memory port, one ALU, one register file.
- Targets the multi-cycle CPU variant. Decodes the same opcode set as the single-cycle control: R-type, LW, SW, BEQ, J, ADDI, SUBI, HALT.
- Handles variable-latency memory through a ready handshake.
- Counts retired instructions and flags illegal opcodes.

Parameters:
CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; meaningful from DECODE onward.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by zero; external gating is pc_write | (pc_write_cond & zero).
- pc_source  out  2  PC mux: 00 ALU result, 01 ALUOut register, 10 jump target.
- iord  out  1  memory address select: 0 PC, 1 ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- reg_dst  out  1  destination register select: 1 rd, 0 rt.
- mem_to_reg  out  1  write-back select: 1 MDR, 0 ALUOut.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU A select: 0 PC, 1 A register.
- alu_src_b  out  2  ALU B select: 00 B register, 01 const 4, 10 sign-extended imm, 11 sign-extended imm<<2.
- alu_op  out  2  ALU operation: 00 add, 01 sub, 10 per funct.
- halted  out  1  high while in HALTED.
- illegal_op  out  1  one-cycle pulse on an undefined opcode.
- instr_done  out  1  one-cycle pulse when an instruction retires.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset and timing
  - Clock is clk. Reset rst_n is asynchronous and active-low.
  - Reset forces state RESET, instret=0 and the internal opcode latch to 0. All outputs are 0 during reset and in RESET.
  - RESET always moves to FETCH on the next cycle.
  - All outputs not listed for a state below are 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes the branch target). Latches opcode internally; later states use only the latch. Next state by opcode:
  - 000000 -> EXEC
  - 100011 (LW) and 101011 (SW) -> MEMADR
  - 000100 (BEQ) -> BRANCH
  - 000010 (J) -> JUMP
  - 001000 (ADDI) and 001001 (SUBI) -> IMMEX
  - 111111 (HALT) -> HALTED
  - any other opcode -> FETCH, with illegal_op=1 this cycle; not counted as retired.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read=1, iord=1. Wait for mem_ready, then go to MEMWB.
- MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH; retire.
- MEMWR: mem_write=1, iord=1. Wait for mem_ready, then go to FETCH; retire in the mem_ready cycle.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALUWB.
- ALUWB: reg_write=1, reg_dst=1. Go to FETCH; retire.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Go to FETCH; retire regardless of zero.
- JUMP: pc_write=1, pc_source=10. Go to FETCH; retire.
- IMMEX: alu_src_a=1, alu_src_b=10. alu_op=00 for ADDI, 01 for SUBI. Go to IMMWB.
- IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH; retire.
- HALTED: halted=1, all strobes 0. Terminal; only rst_n exits. HALT itself retires: instr_done pulses in the DECODE cycle that enters HALTED.
- Retire accounting
  - "Retire" means instr_done=1 combinationally in that state's final cycle.
  - instret increments on the same clock edge and wraps modulo 2^CNT_W.
- Mid-operation events
  - mem_ready high outside FETCH, MEMRD or MEMWR is ignored.
  - Reset asserted mid-instruction abandons the instruction immediately; no partial strobes survive.
- Cycle counts with mem_ready tied to 1: R/ADDI/SUBI 4, LW 5, SW 4, BEQ/J 3, HALT 2 (FETCH + DECODE).

Optional Feature:
- SINGLE_STEP_EN adds two inputs: step_mode (1) and step (1).
- When defined:
  - A step_pending flag sets on a step pulse and clears when FETCH completes.
  - With step_mode=1, FETCH drives all outputs 0 and holds until step_pending=1, so exactly one instruction runs per step pulse.
  - With step_mode=0, behaviour is identical to the build without the macro.
  - step_pending resets to 0.
- When undefined: no extra ports and no extra state.

Decomposition:
- Package mips_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_SUBI, OP_HALT)
  - FSM state enum
  - ALUOP_ADD/SUB/FUNCT
  - ALUB_REG/FOUR/IMM/IMMSH2
  - PCSRC_ALU/ALUOUT/JUMP
- One natural sub-module: retire_counter, a CNT_W-bit counter with increment enable and async active-low reset.

Test Plan:
- Release reset with mem_ready=1 -> 1 cycle in RESET, then FETCH with mem_read=1, pc_write=1, ir_write=1; instret=0.
- R-type opcode 000000, mem_ready=1 -> states FETCH, DECODE, EXEC, ALUWB; reg_write=1 and reg_dst=1 in cycle 4; instret 0->1.
- LW with mem_ready low for 3 cycles in MEMRD -> mem_read=1 and iord=1 held 4 cycles; MEMWB has mem_to_reg=1; 5+3 = 8 cycles total.
- BEQ with zero=1, then BEQ with zero=0 -> pc_write_cond=1 and pc_source=01 in both; instr_done pulses each time.
- Opcode 001100 -> illegal_op single pulse in DECODE, back to FETCH, instret unchanged.
- HALT 111111 -> halted=1 stays high for 20+ cycles with no strobes; rst_n low mid-LW (in MEMRD) -> RESET, all outputs 0; with CNT_W=4 and 16 retired SUBIs -> instret wraps to 0.
